// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request and
// response handshake, with a fixed number of wait states per access.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only when idle)
//   req_wr, req_adr, req_wdata request: 1 = store, byte address, store data
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         load data (0 for stores/errors), error flag
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wr;
    logic [31:0]   r_adr;
    logic [31:0]   r_wdata;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_access;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // Address decode of the latched request
    assign w_idx = r_adr[AW+1:2];
    assign w_err = (r_adr[1:0] != 2'b00) || (r_adr[31:AW+2] != '0);

    // Next-state and wait-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CW'(WAIT_CYCLES);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, request latch and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (w_accept) begin
                r_wr    <= req_wr;
                r_adr   <= req_adr;
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (!r_wr && !w_err) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Storage is never reset; a reset in WAIT returns to IDLE, so no write occurs
    always_ff @(posedge clk) begin
        if (w_access && r_wr && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
